// File: rtl/mpc_seq.sv
// Small sequenced ALU: single-cycle ADD/SUB/AND plus an iterative shift-add
// multiplier, with a valid/ready handshake on both sides.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for an instruction; in_ready high
// MUL   | shift-add multiply in progress, one multiplier bit per cycle
// DONE  | result presented with out_valid high until out_ready
module mpc_seq #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2*W+1:0]     instr,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*W-1:0]     result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count
);

  localparam int SW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  state_t          state;
  logic [1:0]      op;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic [W:0]      sum;
  logic [W:0]      diff;
  logic [2*W-1:0]  alu;
  logic [2*W-1:0]  acc;
  logic [2*W-1:0]  acc_next;
  logic [2*W-1:0]  mcand;
  logic [W-1:0]    mplier;
  logic [SW-1:0]   step;

  assign op = instr[2*W+1 -: 2];
  assign a  = instr[2*W-1 -: W];
  assign b  = instr[W-1:0];

  // Carry/borrow lands in bit W; everything above stays zero.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    alu  = '0;
    unique case (op)
      OP_ADD:  alu[W:0]   = sum;
      OP_SUB:  alu[W:0]   = diff;
      OP_AND:  alu[W-1:0] = a & b;
      default: alu        = '0;
    endcase
  end

  always_comb begin
    acc_next = acc;
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      result    <= '0;
      out_valid <= 1'b0;
      op_count  <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      step      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (op == OP_MUL) begin
              mcand     <= {{W{1'b0}}, a};
              mplier    <= b;
              acc       <= '0;
              step      <= '0;
              result    <= '0;
              out_valid <= 1'b0;
              state     <= MUL;
            end else begin
              result    <= alu;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end

        // Always runs all W steps, even for zero operands, so latency is fixed.
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          step   <= step + SW'(1);
          if (step == SW'(W - 1)) begin
            result    <= acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            op_count  <= op_count + CNT_W'(1);
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpc_seq.sv
// Directed bench for mpc_seq (W=8, CNT_W=4): ALU ops, multiply latency,
// backpressure, reset abort and op_count wrap.
module tb_mpc_seq;

  localparam int W     = 8;
  localparam int CNT_W = 4;

  logic               clk;
  logic               rst_n;
  logic [2*W+1:0]     instr;
  logic               in_valid;
  logic               in_ready;
  logic [2*W-1:0]     result;
  logic               out_valid;
  logic               out_ready;
  logic               busy;
  logic [CNT_W-1:0]   op_count;

  int checks;
  int errors;

  mpc_seq #(.W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .instr     (instr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle op with out_ready high: valid one cycle after accept, consumed next edge.
  task automatic run_alu(input string tag, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [15:0] exp);
    out_ready = 1'b1;
    instr     = {op, a, b};
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    chk({tag, "_valid"},  32'(out_valid), 32'd1);
    chk({tag, "_result"}, 32'(result),    32'(exp));
    chk({tag, "_inrdy"},  32'(in_ready),  32'd0);
    tick();
    chk({tag, "_consumed"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle"},     32'(in_ready),  32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b1;
    instr     = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Asynchronous reset, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_result",   32'(result),    32'd0);
    chk("rst_outvalid", 32'(out_valid), 32'd0);
    chk("rst_busy",     32'(busy),      32'd0);
    chk("rst_opcount",  32'(op_count),  32'd0);
    tick();
    rst_n = 1'b1;
    chk("rst_inready", 32'(in_ready), 32'd1);

    run_alu("add", 2'b00, 8'h4D, 8'h2F, 16'h007C);
    chk("add_count", 32'(op_count), 32'd1);
    run_alu("sub", 2'b01, 8'h4D, 8'hEF, 16'h015E);
    chk("sub_count", 32'(op_count), 32'd2);
    run_alu("and", 2'b10, 8'h4D, 8'h2F, 16'h000D);
    chk("and_count", 32'(op_count), 32'd3);

    // MUL 0xCD*0x2F; an ADD held on in_valid during MUL must be ignored.
    out_ready = 1'b0;
    instr     = {2'b11, 8'hCD, 8'h2F};
    in_valid  = 1'b1;
    tick();
    instr = {2'b00, 8'h11, 8'h22};
    for (int c = 1; c <= 8; c++) begin
      chk("mul_busy",     32'(busy),      32'd1);
      chk("mul_inready",  32'(in_ready),  32'd0);
      chk("mul_outvalid", 32'(out_valid), 32'd0);
      chk("mul_result0",  32'(result),    32'd0);
      tick();
    end
    in_valid = 1'b0;
    chk("mul_done_valid", 32'(out_valid), 32'd1);
    chk("mul_result",     32'(result),    32'h25A3);
    out_ready = 1'b1;
    tick();
    chk("mul_consumed", 32'(out_valid), 32'd0);
    chk("mul_count",    32'(op_count),  32'd4);
    chk("mul_inready1", 32'(in_ready),  32'd1);

    // Backpressure: result held for 5 cycles while in_valid is asserted.
    out_ready = 1'b0;
    instr     = {2'b00, 8'h4D, 8'h2F};
    in_valid  = 1'b1;
    tick();
    instr = {2'b10, 8'hFF, 8'hFF};
    chk("bp_valid",  32'(out_valid), 32'd1);
    chk("bp_result", 32'(result),    32'h007C);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_hold_valid",  32'(out_valid), 32'd1);
      chk("bp_hold_result", 32'(result),    32'h007C);
      chk("bp_hold_inrdy",  32'(in_ready),  32'd0);
      chk("bp_hold_count",  32'(op_count),  32'd4);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_consumed", 32'(out_valid), 32'd0);
    chk("bp_count",    32'(op_count),  32'd5);

    // Reset after four multiply steps aborts the operation.
    out_ready = 1'b0;
    instr     = {2'b11, 8'hCD, 8'h2F};
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_result",   32'(result),    32'd0);
    chk("abort_outvalid", 32'(out_valid), 32'd0);
    chk("abort_busy",     32'(busy),      32'd0);
    chk("abort_count",    32'(op_count),  32'd0);
    tick();
    rst_n = 1'b1;
    chk("abort_inready", 32'(in_ready), 32'd1);
    run_alu("post_rst_add", 2'b00, 8'h01, 8'h01, 16'h0002);
    chk("post_rst_count", 32'(op_count), 32'd1);

    // MUL with a zero operand still takes the full 8 steps.
    out_ready = 1'b0;
    instr     = {2'b11, 8'h00, 8'hFF};
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk("mulz_outvalid", 32'(out_valid), 32'd0);
      chk("mulz_busy",     32'(busy),      32'd1);
      tick();
    end
    chk("mulz_valid",  32'(out_valid), 32'd1);
    chk("mulz_result", 32'(result),    32'd0);
    out_ready = 1'b1;
    tick();
    chk("mulz_count", 32'(op_count), 32'd2);

    // 14 more ops take the 4-bit counter from 2 through 15 back to 0.
    for (int i = 1; i <= 14; i++) begin
      run_alu("wrap_add", 2'b00, 8'(i), 8'(2 * i), 16'(3 * i));
      chk("wrap_count", 32'(op_count), 32'((2 + i) % 16));
    end
    chk("wrap_final", 32'(op_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
